// File: rtl/ahb_tdes_slave_regs.sv
// AHB-Lite register front-end for the Triple-DES core: mode, keys, input block, result and status.
// Optional macro TDES_STRICT_SIZE_EN: reject any transfer whose HSIZE is not 64-bit.
module ahb_tdes_slave_regs #(
  parameter logic [31:0] BASE_ADDR = 32'hAAAAAAA0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [63:0] HWDATA,
  output logic [63:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        encrypt_mode,
  output logic [63:0] key1,
  output logic [63:0] key2,
  output logic [63:0] key3,
  output logic [63:0] data_in,
  output logic        start,
  input  logic        core_busy,
  input  logic        core_done,
  input  logic [63:0] core_data
);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_WAIT_CORE, S_ERR1, S_ERR2} state_t;

  state_t      state_q, state_d;
  logic [3:0]  addr_q, addr_d;
  logic        write_q, write_d;
  logic        mode_q, mode_d;
  logic [63:0] key1_q, key1_d, key2_q, key2_d, key3_q, key3_d;
  logic [63:0] data_in_q, data_in_d;
  logic [63:0] result_q, result_d;
  logic        result_valid_q, result_valid_d;
  logic        overrun_q, overrun_d;
  logic        start_q, start_d;

  logic        accept, hit, size_ok, req_err, ready;
  logic        wr_en, rd_en, launch;

  assign accept = HSEL & HREADY & HTRANS[1];
  assign hit    = (HADDR[31:4] == BASE_ADDR[31:4]);

`ifdef TDES_STRICT_SIZE_EN
  assign size_ok = (HSIZE == 3'b011);
`else
  logic unused_hsize;
  assign unused_hsize = ^HSIZE;
  assign size_ok      = 1'b1;
`endif

  assign wr_en  = (state_q == S_DATA) && write_q;
  assign rd_en  = (state_q == S_DATA) && !write_q;
  assign launch = (wr_en && addr_q == 4'd4 && !core_busy) ||
                  (state_q == S_WAIT_CORE && !core_busy);

  always_comb begin
    unique case (state_q)
      S_DATA:      ready = !(write_q && addr_q == 4'd4 && core_busy);
      S_WAIT_CORE: ready = !core_busy;
      S_ERR1:      ready = 1'b0;
      default:     ready = 1'b1;
    endcase
  end

  always_comb begin
    result_d       = result_q;
    result_valid_d = result_valid_q;
    overrun_d      = overrun_q;
    if (rd_en && addr_q == 4'd5) result_valid_d = 1'b0;
    if (rd_en && addr_q == 4'd6) overrun_d = 1'b0;
    // A new result always wins over a same-cycle consuming read.
    if (core_done) begin
      result_d       = core_data;
      result_valid_d = 1'b1;
      if (result_valid_q) overrun_d = 1'b1;
    end
  end

  // Validity of an offset-5 read uses the post-update flag so a read in the
  // current data phase is accounted for when the next address is decoded.
  always_comb begin
    req_err = !hit || (HADDR[3:0] > 4'd6) || !size_ok ||
              (HWRITE && (HADDR[3:0] == 4'd5 || HADDR[3:0] == 4'd6)) ||
              (!HWRITE && HADDR[3:0] == 4'd5 && !result_valid_d);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    if (state_q == S_ERR1) begin
      state_d = S_ERR2;
    end else if (!ready) begin
      state_d = S_WAIT_CORE;
    end else if (accept) begin
      addr_d  = HADDR[3:0];
      write_d = HWRITE;
      state_d = req_err ? S_ERR1 : S_DATA;
    end else begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    mode_d    = mode_q;
    key1_d    = key1_q;
    key2_d    = key2_q;
    key3_d    = key3_q;
    data_in_d = data_in_q;
    start_d   = launch;
    if (wr_en) begin
      unique case (addr_q)
        4'd0:    mode_d = HWDATA[0];
        4'd1:    key1_d = HWDATA;
        4'd2:    key2_d = HWDATA;
        4'd3:    key3_d = HWDATA;
        default: ;
      endcase
    end
    if (launch) data_in_d = HWDATA;
  end

  always_comb begin
    HRDATA = '0;
    if (rd_en) begin
      unique case (addr_q)
        4'd0:    HRDATA = {63'b0, mode_q};
        4'd4:    HRDATA = data_in_q;
        4'd5:    HRDATA = result_q;
        4'd6:    HRDATA = {60'b0, mode_q, overrun_q, result_valid_q, core_busy};
        default: HRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      write_q        <= 1'b0;
      mode_q         <= 1'b0;
      key1_q         <= '0;
      key2_q         <= '0;
      key3_q         <= '0;
      data_in_q      <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      start_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      write_q        <= write_d;
      mode_q         <= mode_d;
      key1_q         <= key1_d;
      key2_q         <= key2_d;
      key3_q         <= key3_d;
      data_in_q      <= data_in_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overrun_q      <= overrun_d;
      start_q        <= start_d;
    end
  end

  assign HREADYOUT    = ready;
  assign HRESP        = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign encrypt_mode = mode_q;
  assign key1         = key1_q;
  assign key2         = key2_q;
  assign key3         = key3_q;
  assign data_in      = data_in_q;
  assign start        = start_q;

endmodule

// File: tb/tb_ahb_tdes_slave_regs.sv
// Directed bench for ahb_tdes_slave_regs: single AHB transfers with hand-computed expectations.
module tb_ahb_tdes_slave_regs;

  localparam logic [31:0] BASE = 32'hAAAAAAA0;

  logic        HCLK, HRESET, HSEL, HWRITE, HREADYOUT, HRESP;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [63:0] HWDATA, HRDATA;
  logic        encrypt_mode, start, core_busy, core_done;
  logic [63:0] key1, key2, key3, data_in, core_data;

  int n_checks = 0;
  int n_bad    = 0;
  int start_cnt = 0;
  int start_snap;

  logic [63:0] rd;
  int          waits;
  logic        err;

  ahb_tdes_slave_regs #(.BASE_ADDR(BASE)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADYOUT), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .encrypt_mode(encrypt_mode), .key1(key1), .key2(key2), .key3(key3),
    .data_in(data_in), .start(start), .core_busy(core_busy),
    .core_done(core_done), .core_data(core_data)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) if (start) start_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transfer; core_busy is held high for busy_n data-phase cycles. Starts and ends #1 after a rising edge.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [63:0] d,
                      input logic [2:0] sz, input int busy_n,
                      output logic [63:0] rdata, output int nwait, output logic resp);
    core_busy = (busy_n > 0);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = wr; HSIZE = sz;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    HWDATA = wr ? d : '0;
    nwait = 0;
    resp  = HRESP;
    while (!HREADYOUT && nwait < 64) begin
      nwait++;
      @(posedge HCLK); #1;
      if (nwait >= busy_n) core_busy = 1'b0;
      #1;
      resp |= HRESP;
    end
    rdata = HRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic pulse_done(input logic [63:0] v);
    core_done = 1'b1; core_data = v;
    @(posedge HCLK); #1;
    core_done = 1'b0;
  endtask

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = '0; HWRITE = 1'b0;
    HSIZE = 3'b011; HWDATA = '0; core_busy = 1'b0; core_done = 1'b0; core_data = '0;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_hreadyout", HREADYOUT, 1);
    check("rst_hresp", HRESP, 0);
    check("rst_hrdata", HRDATA, 0);
    check("rst_start", start, 0);
    check("rst_mode", encrypt_mode, 0);
    check("rst_key1", key1, 0);
    check("rst_data_in", data_in, 0);
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    // Mode and keys
    xfer(1, BASE + 0, 64'h1, 3'b011, 0, rd, waits, err);
    check("mode_wait", waits, 0); check("mode_resp", err, 0);
    xfer(1, BASE + 1, 64'h1111111111111111, 3'b011, 0, rd, waits, err);
    check("key1_wait", waits, 0); check("key1_resp", err, 0);
    xfer(1, BASE + 2, 64'h2222222222222222, 3'b011, 0, rd, waits, err);
    check("key2_wait", waits, 0); check("key2_resp", err, 0);
    xfer(1, BASE + 3, 64'h3333333333333333, 3'b011, 0, rd, waits, err);
    check("key3_wait", waits, 0); check("key3_resp", err, 0);
    check("mode_reg", encrypt_mode, 1);
    check("key1_reg", key1, 64'h1111111111111111);
    check("key2_reg", key2, 64'h2222222222222222);
    check("key3_reg", key3, 64'h3333333333333333);
    xfer(0, BASE + 0, '0, 3'b011, 0, rd, waits, err);
    check("mode_rd", rd, 64'h1);
    xfer(0, BASE + 2, '0, 3'b011, 0, rd, waits, err);
    check("key2_rd_zero", rd, 0); check("key2_rd_resp", err, 0);

    // Zero-wait launch
    xfer(1, BASE + 4, 64'h1234567890ABCDEF, 3'b011, 0, rd, waits, err);
    check("din_wait", waits, 0);
    check("din_reg", data_in, 64'h1234567890ABCDEF);
    check("start_hi", start, 1);
    @(posedge HCLK); #1;
    check("start_lo", start, 0);
    check("start_cnt1", start_cnt, 1);
    xfer(0, BASE + 4, '0, 3'b011, 0, rd, waits, err);
    check("din_rd", rd, 64'h1234567890ABCDEF);

    // Launch against a busy core
    xfer(1, BASE + 4, 64'h4444444444444444, 3'b011, 4, rd, waits, err);
    check("busy_waits", waits, 4); check("busy_resp", err, 0);
    check("busy_din", data_in, 64'h4444444444444444);
    check("busy_start_hi", start, 1);
    @(posedge HCLK); #1;
    check("busy_start_lo", start, 0);
    check("start_cnt2", start_cnt, 2);

    // Result handling
    pulse_done(64'hDEADBEEF00C0FFEE);
    xfer(0, BASE + 6, '0, 3'b011, 0, rd, waits, err);
    check("stat_valid", rd, 64'hA);
    xfer(0, BASE + 5, '0, 3'b011, 0, rd, waits, err);
    check("res_rd", rd, 64'hDEADBEEF00C0FFEE); check("res_resp", err, 0);
    xfer(0, BASE + 6, '0, 3'b011, 0, rd, waits, err);
    check("stat_consumed", rd, 64'h8);
    xfer(0, BASE + 5, '0, 3'b011, 0, rd, waits, err);
    check("res_empty_resp", err, 1); check("res_empty_wait", waits, 1);
    check("res_empty_rd", rd, 0);

    // Overrun
    pulse_done(64'h0123456789ABCDEF);
    @(posedge HCLK); #1;
    pulse_done(64'hFEDCBA9876543210);
    xfer(0, BASE + 6, '0, 3'b011, 0, rd, waits, err);
    check("stat_overrun", rd, 64'hE);
    xfer(0, BASE + 6, '0, 3'b011, 0, rd, waits, err);
    check("stat_ov_clear", rd, 64'hA);
    xfer(0, BASE + 5, '0, 3'b011, 0, rd, waits, err);
    check("res_latest", rd, 64'hFEDCBA9876543210);

    // core_done in the same cycle as a consuming read
    pulse_done(64'hC1C1C1C1C1C1C1C1);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = BASE + 5; HWRITE = 1'b0; HSIZE = 3'b011;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    core_done = 1'b1; core_data = 64'hC2C2C2C2C2C2C2C2;
    #1;
    check("same_rd_old", HRDATA, 64'hC1C1C1C1C1C1C1C1);
    @(posedge HCLK); #1;
    core_done = 1'b0;
    xfer(0, BASE + 6, '0, 3'b011, 0, rd, waits, err);
    check("same_valid", rd & 64'h2, 64'h2);
    xfer(0, BASE + 5, '0, 3'b011, 0, rd, waits, err);
    check("same_rd_new", rd, 64'hC2C2C2C2C2C2C2C2);

    // Illegal accesses
    xfer(1, BASE + 7, 64'h0, 3'b011, 0, rd, waits, err);
    check("oob_resp", err, 1); check("oob_wait", waits, 1);
    check("oob_mode", encrypt_mode, 1);
    xfer(1, BASE + 5, 64'h0, 3'b011, 0, rd, waits, err);
    check("wr_res_resp", err, 1);
    xfer(1, BASE + 6, 64'h0, 3'b011, 0, rd, waits, err);
    check("wr_stat_resp", err, 1);
    check("err_key1", key1, 64'h1111111111111111);

    xfer(1, BASE + 1, 64'h9999999999999999, 3'b010, 0, rd, waits, err);
`ifdef TDES_STRICT_SIZE_EN
    check("size_resp", err, 1);
    check("size_key1", key1, 64'h1111111111111111);
`else
    check("size_resp", err, 0);
    check("size_key1", key1, 64'h9999999999999999);
`endif

    // Reset while stalled on a busy core
    start_snap = start_cnt;
    core_busy = 1'b1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = BASE + 4; HWRITE = 1'b1; HSIZE = 3'b011;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 64'h5555555555555555;
    check("rst_wait_stall", HREADYOUT, 0);
    @(posedge HCLK); #1;
    check("rst_wait_stall2", HREADYOUT, 0);
    HRESET = 1'b1;
    #1;
    check("midrst_hready", HREADYOUT, 1);
    check("midrst_hresp", HRESP, 0);
    check("midrst_din", data_in, 0);
    core_busy = 1'b0;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    check("midrst_no_start", start_cnt, start_snap);
    check("midrst_din_hold", data_in, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
